serdes_tx_ctrl: RTL and testbench

SERDES_TX_CTRL -- requirements
Module: serdes_tx_ctrl

---
 rtl/serdes_pkg.sv | 18 +
 rtl/serdes_tx_fifo.sv | 65 ++++++
 rtl/serdes_tx_ctrl.sv | 177 +++++++++++++++++
 tb/tb_serdes_tx_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the serial transmit controller.
//   state_e : link state encoding, also driven out on o_State
//   K28_5   : comma character used for alignment, idle fill and clock compensation
//   RD_NEG / RD_POS : running-disparity encodings exchanged with the 8b/10b encoder
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ALIGN = 2'd1,
    ST_IDLE  = 2'd2,
    ST_DATA  = 2'd3
  } state_e;

  localparam logic [7:0]        K28_5  = 8'hBC;
  localparam logic signed [1:0] RD_NEG = 2'sb11;
  localparam logic signed [1:0] RD_POS = 2'sb01;

endpackage

// File: rtl/serdes_tx_fifo.sv
// Input byte buffer for serdes_tx_ctrl.
// Fall-through FIFO: o_Data always shows the head entry; a pop just advances.
// Ports:
//   i_Clk, i_rst_n : clock, asynchronous active-low reset
//   i_Push, i_Data : write request and byte (ignored when full)
//   i_Pop          : read request (ignored when empty)
//   o_Ready        : not full, and held low until the first edge after reset
//   o_Empty        : no entries
//   o_Data         : head entry
module serdes_tx_fifo
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_rst_n,
  input  logic                  i_Push,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Pop,
  output logic                  o_Ready,
  output logic                  o_Empty,
  output logic [DATA_WIDTH-1:0] o_Data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  rdy_en_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;

  always_comb begin
    full     = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(FIFO_DEPTH));
    o_Empty  = (wr_ptr_q == rd_ptr_q);
    o_Ready  = rdy_en_q & ~full;
    push_ok  = i_Push & o_Ready;
    pop_ok   = i_Pop & ~o_Empty;
    wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    o_Data   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Storage carries no reset: an entry is only read after it has been written.
  always_ff @(posedge i_Clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_Data;
  end

endmodule

// File: rtl/serdes_tx_ctrl.sv
// Transmit-side symbol scheduler in front of an 8b/10b encoder.
// Every SYM_PERIOD cycles (slot start = slot counter 0) it decides what the
// encoder sends next: alignment commas after enable, buffered payload bytes,
// or K28.5 fill when idle or when a clock-compensation comma is due.
// Ports:
//   i_Clk, i_rst_n          : clock, asynchronous active-low reset
//   i_Enable                : link enable, sampled at slot start only
//   i_Data, i_Valid, o_Ready: byte input handshake into the buffer
//   o_Sym_Data, o_Sym_K     : symbol for the encoder, held for the whole slot
//   o_Sym_Load              : one-cycle strobe when a new symbol is presented
//   i_Ser_RD, o_RD          : running disparity from / to the encoder
//   o_State, o_Aligned      : link state and "alignment done" flag
module serdes_tx_ctrl
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYM_PERIOD  = 12,
  parameter int ALIGN_CNT   = 16,
  parameter int CC_INTERVAL = 256
) (
  input  logic                    i_Clk,
  input  logic                    i_rst_n,
  input  logic                    i_Enable,
  input  logic [DATA_WIDTH-1:0]   i_Data,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  output logic [DATA_WIDTH-1:0]   o_Sym_Data,
  output logic                    o_Sym_K,
  output logic                    o_Sym_Load,
  input  logic signed [1:0]       i_Ser_RD,
  output logic signed [1:0]       o_RD,
  output logic [1:0]              o_State,
  output logic                    o_Aligned
);

  localparam int CW    = $clog2(SYM_PERIOD);
  localparam int AC_W  = $clog2(ALIGN_CNT + 1);
  localparam int RUN_W = $clog2(CC_INTERVAL + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AC_W-1:0]       align_q, align_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [DATA_WIDTH-1:0] sym_data_q, sym_data_d;
  logic                  sym_k_q, sym_k_d;
  logic                  load_q, load_d;
  logic                  loaded_q, loaded_d;
  logic signed [1:0]     rd_q, rd_d;

  logic                  slot_start;
  logic                  link;
  logic                  emit;
  logic                  emit_byte;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  serdes_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_rst_n (i_rst_n),
    .i_Push  (i_Valid),
    .i_Data  (i_Data),
    .i_Pop   (fifo_pop),
    .o_Ready (o_Ready),
    .o_Empty (fifo_empty),
    .o_Data  (fifo_data)
  );

  always_comb begin
    cnt_d      = (cnt_q == CW'(SYM_PERIOD - 1)) ? '0 : cnt_q + CW'(1);
    slot_start = (cnt_q == '0);
    state_d    = state_q;
    align_d    = align_q;
    run_d      = run_q;
    sym_data_d = sym_data_q;
    sym_k_d    = sym_k_q;
    load_d     = 1'b0;
    loaded_d   = loaded_q;
    rd_d       = rd_q;
    link       = 1'b0;
    emit       = 1'b0;
    emit_byte  = 1'b0;
    fifo_pop   = 1'b0;

    // The encoder reports its disparity at the end of a slot it actually sent.
    if ((cnt_q == CW'(SYM_PERIOD - 1)) && loaded_q) rd_d = i_Ser_RD;

    if (slot_start) begin
      loaded_d = 1'b0;
      if (!i_Enable) begin
        // Dropping enable aborts alignment; buffered bytes stay in the FIFO.
        state_d = ST_OFF;
        align_d = '0;
        run_d   = '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            emit    = 1'b1;
            align_d = AC_W'(1);
            state_d = ST_ALIGN;
          end
          ST_ALIGN: begin
            // Once all alignment commas are out, this slot already behaves as IDLE.
            if (align_q == AC_W'(ALIGN_CNT)) begin
              link = 1'b1;
            end else begin
              emit    = 1'b1;
              align_d = align_q + AC_W'(1);
            end
          end
          default: link = 1'b1;
        endcase

        if (link) begin
          align_d = '0;
          emit    = 1'b1;
          if (run_q == RUN_W'(CC_INTERVAL)) begin
            // Clock-compensation comma: the head byte waits one slot.
            run_d   = '0;
            state_d = ST_DATA;
          end else if (!fifo_empty) begin
            emit_byte = 1'b1;
            fifo_pop  = 1'b1;
            run_d     = run_q + RUN_W'(1);
            state_d   = ST_DATA;
          end else begin
            run_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end

      if (emit) begin
        load_d     = 1'b1;
        loaded_d   = 1'b1;
        sym_k_d    = ~emit_byte;
        sym_data_d = emit_byte ? fifo_data : DATA_WIDTH'(K28_5);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      align_q    <= '0;
      run_q      <= '0;
      sym_data_q <= '0;
      sym_k_q    <= 1'b0;
      load_q     <= 1'b0;
      loaded_q   <= 1'b0;
      rd_q       <= RD_NEG;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      align_q    <= align_d;
      run_q      <= run_d;
      sym_data_q <= sym_data_d;
      sym_k_q    <= sym_k_d;
      load_q     <= load_d;
      loaded_q   <= loaded_d;
      rd_q       <= rd_d;
    end
  end

  assign o_Sym_Data = sym_data_q;
  assign o_Sym_K    = sym_k_q;
  assign o_Sym_Load = load_q;
  assign o_RD       = rd_q;
  assign o_State    = state_q;
  assign o_Aligned  = (state_q == ST_IDLE) || (state_q == ST_DATA);

endmodule

// File: tb/tb_serdes_tx_ctrl.sv
// Randomized bench for serdes_tx_ctrl with a slot-level behavioural model:
// a byte queue, a link mode (off / aligning / linked), comma and run counts.
module tb_serdes_tx_ctrl;

  localparam int SP = 12;
  localparam int AC = 16;
  localparam int CC = 256;
  localparam int M_OFF   = 0;
  localparam int M_ALIGN = 1;
  localparam int M_LINK  = 2;

  logic              clk;
  logic              rst_n;
  logic              i_Enable;
  logic [7:0]        i_Data;
  logic              i_Valid;
  logic              o_Ready;
  logic [7:0]        o_Sym_Data;
  logic              o_Sym_K;
  logic              o_Sym_Load;
  logic signed [1:0] i_Ser_RD;
  logic signed [1:0] o_RD;
  logic [1:0]        o_State;
  logic              o_Aligned;

  serdes_tx_ctrl dut (
    .i_Clk      (clk),
    .i_rst_n    (rst_n),
    .i_Enable   (i_Enable),
    .i_Data     (i_Data),
    .i_Valid    (i_Valid),
    .o_Ready    (o_Ready),
    .o_Sym_Data (o_Sym_Data),
    .o_Sym_K    (o_Sym_K),
    .o_Sym_Load (o_Sym_Load),
    .i_Ser_RD   (i_Ser_RD),
    .o_RD       (o_RD),
    .o_State    (o_State),
    .o_Aligned  (o_Aligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]        q[$];
  int                mode;
  int                align_n;
  int                run_n;
  int                e;
  logic signed [1:0] m_rd;
  bit                m_loaded;
  bit                m_rdy;
  bit                exp_load;
  logic [7:0]        exp_data;
  bit                exp_k;
  int                n_forced;
  int                n_bytes_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode     = M_OFF;
    align_n  = 0;
    run_n    = 0;
    e        = 0;
    m_rd     = 2'sb11;
    m_loaded = 0;
    m_rdy    = 0;
    exp_load = 0;
    exp_data = 8'h00;
    exp_k    = 0;
  endtask

  task automatic emit(input bit is_k, input logic [7:0] d);
    exp_load = 1;
    exp_k    = is_k;
    exp_data = d;
    m_loaded = 1;
  endtask

  // One rising edge of the model; inputs still hold their pre-edge values.
  task automatic model_step();
    bit acc;
    acc      = i_Valid && m_rdy;
    exp_load = 0;
    if ((e % SP) == SP - 1 && m_loaded) m_rd = i_Ser_RD;
    if ((e % SP) == 0) begin
      m_loaded = 0;
      if (!i_Enable) begin
        mode = M_OFF; align_n = 0; run_n = 0;
      end else if (mode == M_OFF) begin
        emit(1, 8'hBC); mode = M_ALIGN; align_n = 1;
      end else if (mode == M_ALIGN && align_n < AC) begin
        emit(1, 8'hBC); align_n++;
      end else begin
        mode = M_LINK;
        if (run_n == CC) begin
          emit(1, 8'hBC); run_n = 0; n_forced++;
        end else if (q.size() > 0) begin
          emit(0, q.pop_front()); run_n++; n_bytes_out++;
        end else begin
          emit(1, 8'hBC); run_n = 0;
        end
      end
    end
    if (acc) q.push_back(i_Data);
    m_rdy = (q.size() < 4);
    e++;
  endtask

  task automatic check_outputs();
    chk("load", o_Sym_Load, exp_load);
    chk("sym_data", o_Sym_Data, exp_data);
    chk("sym_k", o_Sym_K, exp_k);
    chk("ready", o_Ready, m_rdy);
    chk("rd", {30'b0, o_RD}, {30'b0, m_rd});
    chk("aligned", o_Aligned, (mode == M_LINK));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_random(input int valid_pct);
    i_Valid  = ($urandom_range(99) < valid_pct);
    i_Data   = 8'($urandom);
    i_Ser_RD = $urandom_range(1) ? 2'sb01 : 2'sb11;
  endtask

  task automatic run_cycles(input int n, input int valid_pct);
    for (int i = 0; i < n; i++) begin
      cycle();
      drive_random(valid_pct);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data"}, o_Sym_Data, 8'h00);
    chk({tag, "_k"}, o_Sym_K, 1'b0);
    chk({tag, "_load"}, o_Sym_Load, 1'b0);
    chk({tag, "_rd"}, {30'b0, o_RD}, {30'b0, 2'b11});
    chk({tag, "_ready"}, o_Ready, 1'b0);
    chk({tag, "_aligned"}, o_Aligned, 1'b0);
    chk({tag, "_state"}, o_State, 2'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    model_reset();
    rst_n    = 1'b1;
    i_Enable = 1'b1;
    #1;
    chk("ready_before_edge", o_Ready, 1'b0);
  endtask

  initial begin
    int bytes_before;
    rst_n    = 1'b0;
    i_Enable = 1'b0;
    i_Valid  = 1'b0;
    i_Data   = 8'h00;
    i_Ser_RD = 2'sb11;
    n_forced = 0;
    n_bytes_out = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    release_reset();

    // Alignment then idle commas, no payload
    run_cycles(SP * (AC + 4), 0);
    chk("aligned_after_align", o_Aligned, 1'b1);

    // Three directed bytes pushed back-to-back while idle
    i_Valid = 1'b1; i_Data = 8'h3C; cycle();
    i_Data = 8'hA5; cycle();
    i_Data = 8'h00; cycle();
    i_Valid = 1'b0;
    run_cycles(SP * 6, 0);
    chk("directed_drained", q.size(), 0);

    // Sparse random traffic
    run_cycles(SP * 40, 30);

    // Continuous traffic long enough for a clock-compensation comma
    n_forced = 0;
    bytes_before = n_bytes_out;
    run_cycles(SP * (CC + 24), 100);
    chk("forced_comma_count", n_forced, 1);
    chk("bytes_in_long_run", n_bytes_out - bytes_before, SP * (CC + 24) / SP - 1);

    // Drop enable mid-slot, keep pushing, then re-enable: alignment replays
    for (int i = 0; i < SP && (e % SP) != 5; i++) begin
      cycle();
      drive_random(100);
    end
    i_Enable = 1'b0;
    run_cycles(SP * 6, 100);
    chk("fifo_full_while_off", o_Ready, 1'b0);
    i_Enable = 1'b1;
    run_cycles(SP * (AC + 14), 30);

    // Reset in the middle of a data run
    run_cycles(SP * 5 + 4, 100);
    chk("in_data_state", o_State, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    model_reset();
    repeat (2) @(posedge clk);
    i_Valid = 1'b0;
    release_reset();
    run_cycles(SP * (AC + 10), 40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
